// File: rtl/fifo_rd_stream_if.sv
// Read-side FIFO port plus downstream valid/ready stream, bundled for fifo_rd_stream.
// master = the stream adapter; slave = the FIFO/consumer environment around it.
interface fifo_rd_stream_if #(
  parameter int DATA_SIZE = 8
);
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [DATA_SIZE-1:0] fifo_rd_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read-side consumer: credit-based reads, 2-entry skid buffer absorbing the
// FIFO's 1-cycle read latency, registered valid/ready output and a delivered-word counter.
module fifo_rd_stream #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_W     = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic             ovf_err
);

  logic [1:0]           occ, occ_d;
  logic                 infl;
  logic [DATA_SIZE-1:0] slot   [2];
  logic [DATA_SIZE-1:0] slot_d [2];
  logic                 ovf_d;
  logic                 pop;
  logic [2:0]           credit;

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = slot[0];
  assign pop         = bus.m_valid & bus.m_ready;

  // Words captured or in flight after this edge; a read is allowed only if it still fits.
  assign credit         = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  assign bus.fifo_rd_en = !rd_rst & !bus.fifo_empty & (credit < 3'd2);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the branches infers a latch.
    slot_d[0] = slot[0];
    slot_d[1] = slot[1];
    occ_d     = credit[1:0];
    ovf_d     = ovf_err;
    if (infl) begin
      case (occ)
        2'd0: slot_d[0] = bus.fifo_rd_data;
        2'd1: begin
          if (pop) slot_d[0] = bus.fifo_rd_data;
          else     slot_d[1] = bus.fifo_rd_data;
        end
        default: begin
          if (pop) begin
            slot_d[0] = slot[1];
            slot_d[1] = bus.fifo_rd_data;
          end else begin
            // Capture into a full buffer cannot happen with correct credit; flag and drop.
            ovf_d = 1'b1;
            occ_d = 2'd2;
          end
        end
      endcase
    end else if (pop) begin
      slot_d[0] = slot[1];
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      // NOTE: the buffer is reset so m_data reads zero after reset, not stale data.
      occ      <= 2'd0;
      infl     <= 1'b0;
      slot[0]  <= '0;
      slot[1]  <= '0;
      word_cnt <= '0;
      ovf_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      occ      <= occ_d;
      infl     <= bus.fifo_rd_en;
      slot[0]  <= slot_d[0];
      slot[1]  <= slot_d[1];
      word_cnt <= word_cnt + CNT_W'(pop);
      ovf_err  <= ovf_d;
    end
  end

endmodule
